// File: rtl/calc_engine.sv
`timescale 1ns/1ps
// calc_engine: keypad-driven sign-magnitude calculator core, evaluated left to right.
// Add/sub resolve in one cycle; multiply runs a WIDTH-step shift-add loop while busy.
module calc_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             newkey,
    input  logic [4:0]       keycode,
    output logic [WIDTH-1:0] value,
    output logic             ovw,
    output logic             sign,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH+1:0] ONE_TC = 1;

    typedef enum logic [1:0] {S_READY, S_MULT, S_ERROR} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

    state_t             state_q, state_d;
    op_t                pending_q, pending_d;
    op_t                key_op;
    logic [WIDTH-1:0]   acc_mag_q, acc_mag_d;
    logic               acc_sign_q, acc_sign_d;
    logic [WIDTH-1:0]   entry_q, entry_d;
    logic               new_entry_q, new_entry_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               sign_q, sign_d;
    logic               ovw_q, ovw_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               clear_all;

    // Add/sub datapath: two's complement with two guard bits, then back to sign-magnitude.
    logic [WIDTH+1:0] acc_ext, ent_ext, acc_tc, sum_tc, sum_mag;
    logic             sum_neg, sum_ovf;
    logic             prod_hi_nz, prod_neg;

    always_comb begin
        acc_ext    = {2'b00, acc_mag_q};
        ent_ext    = {2'b00, entry_q};
        acc_tc     = acc_sign_q ? (~acc_ext + ONE_TC) : acc_ext;
        sum_tc     = (pending_q == OP_SUB) ? (acc_tc - ent_ext) : (acc_tc + ent_ext);
        sum_neg    = sum_tc[WIDTH+1];
        sum_mag    = sum_neg ? (~sum_tc + ONE_TC) : sum_tc;
        sum_ovf    = |sum_mag[WIDTH+1:WIDTH];
        prod_hi_nz = |prod_q[2*WIDTH-1:WIDTH];
        prod_neg   = acc_sign_q & (|prod_q);
    end

    always_comb begin
        case (keycode[2:0])
            3'd2:    key_op = OP_ADD;
            3'd3:    key_op = OP_SUB;
            3'd4:    key_op = OP_MUL;
            default: key_op = OP_NONE;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        acc_mag_d   = acc_mag_q;
        acc_sign_d  = acc_sign_q;
        entry_d     = entry_q;
        new_entry_d = new_entry_q;
        value_d     = value_q;
        sign_d      = sign_q;
        ovw_d       = ovw_q;
        busy_d      = busy_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        clear_all   = 1'b0;

        case (state_q)
            S_READY: begin
                if (newkey) begin
                    if (keycode[4]) begin
                        if (new_entry_q) begin
                            entry_d     = {{(WIDTH-4){1'b0}}, keycode[3:0]};
                            new_entry_d = 1'b0;
                        end else if (entry_q[WIDTH-1 -: 4] == 4'd0) begin
                            entry_d = {entry_q[WIDTH-5:0], keycode[3:0]};
                        end
                        value_d = entry_d;
                        sign_d  = 1'b0;
                    end else begin
                        case (keycode[3:0])
                            4'd0: clear_all = 1'b1;
                            4'd1: begin
                                entry_d     = '0;
                                new_entry_d = 1'b1;
                                value_d     = '0;
                                sign_d      = 1'b0;
                            end
                            4'd2, 4'd3, 4'd4, 4'd5: begin
                                // Back-to-back operators only swap the pending op.
                                if (keycode[3:0] != 4'd5 && new_entry_q) begin
                                    pending_d = key_op;
                                    value_d   = acc_mag_q;
                                    sign_d    = acc_sign_q;
                                end else begin
                                    pending_d   = key_op;
                                    new_entry_d = 1'b1;
                                    entry_d     = '0;
                                    case (pending_q)
                                        OP_NONE: begin
                                            acc_mag_d  = entry_q;
                                            acc_sign_d = 1'b0;
                                            value_d    = entry_q;
                                            sign_d     = 1'b0;
                                        end
                                        OP_MUL: begin
                                            state_d  = S_MULT;
                                            busy_d   = 1'b1;
                                            prod_d   = '0;
                                            mcand_d  = {{WIDTH{1'b0}}, acc_mag_q};
                                            mplier_d = entry_q;
                                            cnt_d    = '0;
                                        end
                                        default: begin
                                            value_d = sum_mag[WIDTH-1:0];
                                            sign_d  = sum_neg;
                                            if (sum_ovf) begin
                                                ovw_d   = 1'b1;
                                                state_d = S_ERROR;
                                            end else begin
                                                acc_mag_d  = sum_mag[WIDTH-1:0];
                                                acc_sign_d = sum_neg;
                                            end
                                        end
                                    endcase
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_MULT: begin
                if (cnt_q == CW'(WIDTH)) begin
                    busy_d  = 1'b0;
                    value_d = prod_q[WIDTH-1:0];
                    sign_d  = prod_neg;
                    if (prod_hi_nz) begin
                        ovw_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        acc_mag_d  = prod_q[WIDTH-1:0];
                        acc_sign_d = prod_neg;
                        state_d    = S_READY;
                    end
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            S_ERROR: begin
                if (newkey && keycode == 5'd0) begin
                    clear_all = 1'b1;
                end
            end
            default: state_d = S_READY;
        endcase

        if (clear_all) begin
            state_d     = S_READY;
            pending_d   = OP_NONE;
            acc_mag_d   = '0;
            acc_sign_d  = 1'b0;
            entry_d     = '0;
            new_entry_d = 1'b1;
            value_d     = '0;
            sign_d      = 1'b0;
            ovw_d       = 1'b0;
            busy_d      = 1'b0;
            prod_d      = '0;
            mcand_d     = '0;
            mplier_d    = '0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_READY;
            pending_q   <= OP_NONE;
            acc_mag_q   <= '0;
            acc_sign_q  <= 1'b0;
            entry_q     <= '0;
            new_entry_q <= 1'b1;
            value_q     <= '0;
            sign_q      <= 1'b0;
            ovw_q       <= 1'b0;
            busy_q      <= 1'b0;
            prod_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            acc_mag_q   <= acc_mag_d;
            acc_sign_q  <= acc_sign_d;
            entry_q     <= entry_d;
            new_entry_q <= new_entry_d;
            value_q     <= value_d;
            sign_q      <= sign_d;
            ovw_q       <= ovw_d;
            busy_q      <= busy_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

    assign value = value_q;
    assign ovw   = ovw_q;
    assign sign  = sign_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_calc_engine.sv
`timescale 1ns/1ps
// tb_calc_engine: directed key sequences plus random key streams against a signed-integer
// calculator model; expected displays are queued at key time and matched by a monitor.
module tb_calc_engine;
    localparam int W  = 16;
    localparam int EW = 26;   // {latency[7:0], ovw, sign, value[15:0]}

    localparam logic [4:0] K_CLR = 5'd0;
    localparam logic [4:0] K_CE  = 5'd1;
    localparam logic [4:0] K_ADD = 5'd2;
    localparam logic [4:0] K_SUB = 5'd3;
    localparam logic [4:0] K_MUL = 5'd4;
    localparam logic [4:0] K_EQ  = 5'd5;

    localparam int OP_NONE = 0, OP_ADD = 1, OP_SUB = 2, OP_MUL = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         newkey = 1'b0;
    logic [4:0]   keycode = 5'd0;
    logic [W-1:0] value;
    logic         ovw, sign, busy;

    int checks = 0;
    int errors = 0;

    calc_engine #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .newkey  (newkey),
        .keycode (keycode),
        .value   (value),
        .ovw     (ovw),
        .sign    (sign),
        .busy    (busy)
    );

    // Clock and per-edge bookkeeping
    always #5 clock = ~clock;

    logic key_q = 1'b0, rst_q = 1'b1, busy_prev = 1'b0;
    int   cyc = 0;
    always @(posedge clock) begin
        key_q     <= newkey;
        rst_q     <= reset;
        busy_prev <= busy;
        cyc       <= cyc + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Reference model: plain signed-integer calculator
    longint m_acc;
    int     m_entry, m_pend, m_val;
    bit     m_new, m_err, m_sign, m_ovw;

    function automatic void model_reset();
        m_acc = 0; m_entry = 0; m_pend = OP_NONE; m_new = 1'b1;
        m_err = 1'b0; m_val = 0; m_sign = 1'b0; m_ovw = 1'b0;
    endfunction

    function automatic logic [EW-1:0] model_key(input logic [4:0] k);
        int     lat = 0;
        int     newop;
        longint r, mag;
        if (m_err) begin
            if (k == K_CLR) model_reset();
        end else if (k[4]) begin
            if (m_new) begin
                m_entry = int'(k[3:0]);
                m_new = 1'b0;
            end else if (m_entry < 'h1000) begin
                m_entry = m_entry * 16 + int'(k[3:0]);
            end
            m_val = m_entry; m_sign = 1'b0;
        end else if (k == K_CLR) begin
            model_reset();
        end else if (k == K_CE) begin
            m_entry = 0; m_new = 1'b1; m_val = 0; m_sign = 1'b0;
        end else if (k >= K_ADD && k <= K_EQ) begin
            newop = (k == K_ADD) ? OP_ADD : (k == K_SUB) ? OP_SUB : (k == K_MUL) ? OP_MUL : OP_NONE;
            if (k != K_EQ && m_new) begin
                m_pend = newop;
                m_val  = int'(m_acc < 0 ? -m_acc : m_acc);
                m_sign = (m_acc < 0);
            end else begin
                case (m_pend)
                    OP_NONE: r = m_entry;
                    OP_ADD:  r = m_acc + m_entry;
                    OP_SUB:  r = m_acc - m_entry;
                    default: begin r = m_acc * m_entry; lat = 17; end
                endcase
                mag    = (r < 0) ? -r : r;
                m_val  = int'(mag % 65536);
                m_sign = (r < 0);
                if (mag > 65535) begin
                    m_err = 1'b1; m_ovw = 1'b1;
                end else begin
                    m_acc = r;
                end
                m_pend = newop; m_new = 1'b1; m_entry = 0;
            end
        end
        return {8'(lat), m_ovw, m_sign, 16'(m_val)};
    endfunction

    // Scoreboard
    logic [EW-1:0] exp_q[$];
    int            stamp_q[$];

    // Monitor: a response is due one edge after an accepted key, or when busy drops.
    logic [EW-1:0] mon_e;
    int            mon_st;
    always @(negedge clock) begin
        if (!rst_q && !busy && (key_q || busy_prev)) begin
            if (exp_q.size() == 0) begin
                chk("spurious_response", 32'd1, 32'd0);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_st = stamp_q.pop_front();
                chk("value", 32'(value), 32'(mon_e[15:0]));
                chk("sign", 32'(sign), 32'(mon_e[16]));
                chk("ovw", 32'(ovw), 32'(mon_e[17]));
                chk("latency", 32'(cyc - mon_st - 1), 32'(mon_e[25:18]));
            end
        end
    end

    // Driver
    task automatic press(input logic [4:0] k);
        int guard = 0;
        while (busy && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (busy) chk("busy_timeout", 32'(busy), 32'd0);
        exp_q.push_back(model_key(k));
        stamp_q.push_back(cyc);
        newkey  = 1'b1;
        keycode = k;
        @(negedge clock);
        newkey  = 1'b0;
    endtask

    function automatic logic [4:0] char_key(input byte c);
        int v = int'(c);
        if (v >= 48 && v <= 57) return {1'b1, 4'(v - 48)};   // '0'..'9'
        if (v >= 65 && v <= 70) return {1'b1, 4'(v - 55)};   // 'A'..'F'
        case (v)
            43:      return K_ADD;  // '+'
            45:      return K_SUB;  // '-'
            42:      return K_MUL;  // '*'
            61:      return K_EQ;   // '='
            99:      return K_CE;   // 'c'
            88:      return K_CLR;  // 'X'
            default: return 5'd9;   // unused keycode
        endcase
    endfunction

    task automatic run_seq(input string s);
        for (int i = 0; i < s.len(); i++) press(char_key(s[i]));
    endtask

    task automatic random_key();
        int r = $urandom_range(0, 99);
        if (m_err && r < 40)  press(K_CLR);
        else if (r < 50)      press({1'b1, 4'($urandom_range(0, 15))});
        else if (r < 62)      press(K_ADD);
        else if (r < 70)      press(K_SUB);
        else if (r < 78)      press(K_MUL);
        else if (r < 88)      press(K_EQ);
        else if (r < 92)      press(K_CE);
        else if (r < 95)      press(K_CLR);
        else                  press(5'($urandom_range(6, 15)));
        repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    initial begin
        int guard;
        model_reset();
        repeat (3) @(negedge clock);
        chk("reset_value", 32'(value), 32'd0);
        chk("reset_sign", 32'(sign), 32'd0);
        chk("reset_ovw", 32'(ovw), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_seq("12345c7");
        run_seq("X0012+34=");
        run_seq("X10-30=+20=");
        run_seq("X?9");

        // Multiply timing, value hold, and a digit ignored mid-multiply
        run_seq("X100*21");
        press(K_EQ);
        for (int i = 0; i <= 16; i++) begin
            chk("mult_busy", 32'(busy), 32'd1);
            chk("mult_hold", 32'(value), 32'h21);
            if (i == 4) begin
                newkey = 1'b1; keycode = 5'h19;
            end else if (i == 5) begin
                newkey = 1'b0;
            end
            @(negedge clock);
        end
        chk("mult_done_busy", 32'(busy), 32'd0);
        chk("mult_result", 32'(value), 32'h2100);

        run_seq("X2+3*4=");
        run_seq("XFFFF+1=5X");

        // Reset in the middle of a multiply
        run_seq("XFFFF*2");
        press(K_EQ);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midmul_busy", 32'(busy), 32'd0);
        chk("midmul_value", 32'(value), 32'd0);
        chk("midmul_sign", 32'(sign), 32'd0);
        chk("midmul_ovw", 32'(ovw), 32'd0);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        stamp_q.delete();
        run_seq("2+2=");

        for (int n = 0; n < 400; n++) random_key();

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
